// File: rtl/axis_frame_source.sv
// axis_frame_source
// Frame-rate AXI-Stream pixel source. One IMG_W x IMG_H frame per accepted
// start, raster order, tlast on the last pixel of each line, tuser on the
// first pixel of the frame. The sink is always ready (no tready).
//
// Ports
//   clk_i          in   system clock
//   rstn_i         in   synchronous reset, active low
//   start_i        in   start one frame (only honoured in IDLE)
//   pattern_i[1:0] in   0=h-ramp 1=v-ramp 2=checker 3=LFSR, sampled with start
//   busy_o         out  high while a frame is in progress (LINE/GAP/DONE)
//   frame_done_o   out  one-cycle pulse after the final beat
//   axis_tdata_o   out  pixel value
//   axis_tvalid_o  out  beat valid
//   axis_tlast_o   out  last pixel of line
//   axis_tuser_o   out  first pixel of frame
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i, all outputs low
// LINE  | presenting beat (x,y) on the stream this cycle
// GAP   | inter-line idle, gap_cnt counts down to the next line's first beat
// DONE  | frame_done pulse cycle, busy still high

module axis_frame_source #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int LINE_GAP = 0
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       start_i,
    input  logic [1:0] pattern_i,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic [7:0] axis_tdata_o,
    output logic       axis_tvalid_o,
    output logic       axis_tlast_o,
    output logic       axis_tuser_o
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int GW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
    // Gap counter is loaded with LINE_GAP-1 and runs down to zero, giving
    // exactly LINE_GAP idle cycles; unused when LINE_GAP is zero.
    localparam logic [GW-1:0] GAP_LOAD = (LINE_GAP > 0) ? GW'(LINE_GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LINE,
        S_GAP,
        S_DONE
    } state_t;

    state_t          state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [GW-1:0]   gap_cnt;
    logic [7:0]      lfsr;
    logic [1:0]      pat;

    logic [XW-1:0]   x_inc;
    logic [YW-1:0]   y_inc;
    logic [7:0]      lfsr_adv;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    function automatic logic [7:0] pixel(input logic [1:0]    p,
                                         input logic [XW-1:0] px,
                                         input logic [YW-1:0] py,
                                         input logic [7:0]    rnd);
        logic [7:0] x8;
        logic [7:0] y8;
        x8 = 8'(px);
        y8 = 8'(py);
        case (p)
            2'd0:    return x8;
            2'd1:    return y8;
            2'd2:    return (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
            default: return rnd;
        endcase
    endfunction

    assign x_inc    = x + XW'(1);
    assign y_inc    = y + YW'(1);
    // The register always holds the value for the beat being presented;
    // advancing it on every LINE cycle keeps the sequence continuous across
    // lines and gaps.
    assign lfsr_adv = lfsr_step(lfsr);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state         <= S_IDLE;
            x             <= '0;
            y             <= '0;
            gap_cnt       <= '0;
            lfsr          <= 8'h01;
            pat           <= 2'd0;
            busy_o        <= 1'b0;
            frame_done_o  <= 1'b0;
            axis_tdata_o  <= 8'h00;
            axis_tvalid_o <= 1'b0;
            axis_tlast_o  <= 1'b0;
            axis_tuser_o  <= 1'b0;
        end else begin
            frame_done_o  <= 1'b0;
            axis_tdata_o  <= 8'h00;
            axis_tvalid_o <= 1'b0;
            axis_tlast_o  <= 1'b0;
            axis_tuser_o  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state         <= S_LINE;
                        pat           <= pattern_i;
                        x             <= '0;
                        y             <= '0;
                        lfsr          <= 8'h01;
                        busy_o        <= 1'b1;
                        axis_tvalid_o <= 1'b1;
                        axis_tdata_o  <= pixel(pattern_i, '0, '0, 8'h01);
                        axis_tlast_o  <= (X_LAST == '0);
                        axis_tuser_o  <= 1'b1;
                    end
                end

                S_LINE: begin
                    lfsr <= lfsr_adv;
                    if (x == X_LAST) begin
                        x <= '0;
                        if (y == Y_LAST) begin
                            state        <= S_DONE;
                            frame_done_o <= 1'b1;
                        end else if (LINE_GAP == 0) begin
                            y             <= y_inc;
                            axis_tvalid_o <= 1'b1;
                            axis_tdata_o  <= pixel(pat, '0, y_inc, lfsr_adv);
                        end else begin
                            y       <= y_inc;
                            gap_cnt <= GAP_LOAD;
                            state   <= S_GAP;
                        end
                    end else begin
                        x             <= x_inc;
                        axis_tvalid_o <= 1'b1;
                        axis_tdata_o  <= pixel(pat, x_inc, y, lfsr_adv);
                        axis_tlast_o  <= (x_inc == X_LAST);
                    end
                end

                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state         <= S_LINE;
                        axis_tvalid_o <= 1'b1;
                        axis_tdata_o  <= pixel(pat, x, y, lfsr);
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end

                S_DONE: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_source.sv
// Testbench for axis_frame_source: four instances with different geometries,
// a scoreboard queue per instance filled by the stimulus and drained by a
// monitor on every valid beat, plus directed timing checks.

module tb_axis_frame_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn [4];
    logic       st   [4];
    logic [1:0] pat  [4];
    logic       busy [4];
    logic       fd   [4];
    logic       tv   [4];
    logic       tl   [4];
    logic       tu   [4];
    logic [7:0] td   [4];

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    beat_t exp_q [4][$];
    int    n_chk = 0;
    int    n_pass = 0;
    int    fd_cnt [4] = '{0, 0, 0, 0};
    bit    mon_en = 1'b0;

    axis_frame_source #(.IMG_W(4), .IMG_H(2), .LINE_GAP(0)) u_d0 (
        .clk_i(clk), .rstn_i(rstn[0]), .start_i(st[0]), .pattern_i(pat[0]),
        .busy_o(busy[0]), .frame_done_o(fd[0]), .axis_tdata_o(td[0]),
        .axis_tvalid_o(tv[0]), .axis_tlast_o(tl[0]), .axis_tuser_o(tu[0]));

    axis_frame_source #(.IMG_W(4), .IMG_H(3), .LINE_GAP(2)) u_d1 (
        .clk_i(clk), .rstn_i(rstn[1]), .start_i(st[1]), .pattern_i(pat[1]),
        .busy_o(busy[1]), .frame_done_o(fd[1]), .axis_tdata_o(td[1]),
        .axis_tvalid_o(tv[1]), .axis_tlast_o(tl[1]), .axis_tuser_o(tu[1]));

    axis_frame_source #(.IMG_W(16), .IMG_H(16), .LINE_GAP(0)) u_d2 (
        .clk_i(clk), .rstn_i(rstn[2]), .start_i(st[2]), .pattern_i(pat[2]),
        .busy_o(busy[2]), .frame_done_o(fd[2]), .axis_tdata_o(td[2]),
        .axis_tvalid_o(tv[2]), .axis_tlast_o(tl[2]), .axis_tuser_o(tu[2]));

    axis_frame_source #(.IMG_W(3), .IMG_H(2), .LINE_GAP(0)) u_d3 (
        .clk_i(clk), .rstn_i(rstn[3]), .start_i(st[3]), .pattern_i(pat[3]),
        .busy_o(busy[3]), .frame_done_o(fd[3]), .axis_tdata_o(td[3]),
        .axis_tvalid_o(tv[3]), .axis_tlast_o(tl[3]), .axis_tuser_o(tu[3]));

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic pb(input int id, input int d, input bit l, input bit u);
        beat_t b;
        b.d = 8'(d);
        b.l = l;
        b.u = u;
        exp_q[id].push_back(b);
    endtask

    // Reference frame generator, written from the pattern definitions.
    task automatic push_frame(input int id, input int w, input int h, input int p);
        logic [7:0] r;
        int         d;
        r = 8'h01;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                case (p)
                    0:       d = xx & 255;
                    1:       d = yy & 255;
                    2:       d = (((xx >> 3) ^ (yy >> 3)) & 1) ? 255 : 0;
                    default: d = int'(r);
                endcase
                pb(id, d, xx == w - 1, (xx == 0) && (yy == 0));
                r = r[0] ? ((r >> 1) ^ 8'hB8) : (r >> 1);
            end
        end
    endtask

    // Returns at the falling edge of the cycle carrying the first beat.
    task automatic do_start(input int id, input int p);
        @(negedge clk);
        st[id]  = 1'b1;
        pat[id] = 2'(p);
        @(negedge clk);
        st[id]  = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        int n;
        n = 0;
        while (busy[id] === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("dut%0d returns to idle", id), int'(n < 2000), 1);
    endtask

    always @(negedge clk) begin : monitor
        beat_t e;
        if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
                if (fd[i]) fd_cnt[i]++;
                if (tv[i]) begin
                    chk($sformatf("dut%0d beat expected", i), int'(exp_q[i].size() > 0), 1);
                    if (exp_q[i].size() > 0) begin
                        e = exp_q[i].pop_front();
                        chk($sformatf("dut%0d tdata", i), int'(td[i]), int'(e.d));
                        chk($sformatf("dut%0d tlast", i), int'(tl[i]), int'(e.l));
                        chk($sformatf("dut%0d tuser", i), int'(tu[i]), int'(e.u));
                    end
                end else begin
                    chk($sformatf("dut%0d idle outputs zero", i), int'({td[i], tl[i], tu[i]}), 0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pix [256];
        int         f0;

        for (int i = 0; i < 4; i++) begin
            rstn[i] = 1'b0;
            st[i]   = 1'b0;
            pat[i]  = 2'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dut%0d reset busy", i), int'(busy[i]), 0);
            chk($sformatf("dut%0d reset frame_done", i), int'(fd[i]), 0);
            chk($sformatf("dut%0d reset tvalid", i), int'(tv[i]), 0);
            chk($sformatf("dut%0d reset data/last/user", i), int'({td[i], tl[i], tu[i]}), 0);
            rstn[i] = 1'b1;
        end
        mon_en = 1'b1;

        // 4x2 horizontal ramp: beats at cycles 1-8, done at 9, busy 1-9.
        pb(0, 0, 0, 1); pb(0, 1, 0, 0); pb(0, 2, 0, 0); pb(0, 3, 1, 0);
        pb(0, 0, 0, 0); pb(0, 1, 0, 0); pb(0, 2, 0, 0); pb(0, 3, 1, 0);
        do_start(0, 0);
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("ramp busy k=%0d", k), int'(busy[0]), int'(k <= 9));
            chk($sformatf("ramp frame_done k=%0d", k), int'(fd[0]), int'(k == 9));
            chk($sformatf("ramp tvalid k=%0d", k), int'(tv[0]), int'(k <= 8));
            @(negedge clk);
        end

        // 4x3 vertical ramp with a 2-cycle line gap: done 16 cycles after first beat.
        for (int l = 0; l < 3; l++)
            for (int xx = 0; xx < 4; xx++)
                pb(1, l, xx == 3, (l == 0) && (xx == 0));
        do_start(1, 1);
        for (int k = 1; k <= 18; k++) begin
            chk($sformatf("gap tvalid k=%0d", k), int'(tv[1]),
                int'((k <= 4) || (k >= 7 && k <= 10) || (k >= 13 && k <= 16)));
            chk($sformatf("gap frame_done k=%0d", k), int'(fd[1]), int'(k == 17));
            chk($sformatf("gap busy k=%0d", k), int'(busy[1]), int'(k <= 17));
            @(negedge clk);
        end

        // 16x16 checkerboard, spot-checked around the 8-pixel boundaries.
        push_frame(2, 16, 16, 2);
        do_start(2, 2);
        for (int k = 0; k < 256; k++) begin
            pix[k] = td[2];
            @(negedge clk);
        end
        chk("checker (7,0)", int'(pix[7]), 8'h00);
        chk("checker (8,0)", int'(pix[8]), 8'hFF);
        chk("checker (0,8)", int'(pix[128]), 8'hFF);
        chk("checker (8,8)", int'(pix[136]), 8'h00);
        wait_idle(2);

        // 3x2 LFSR; pattern_i changes and start pulses mid-frame must be ignored.
        pb(3, 8'h01, 0, 1); pb(3, 8'hB8, 0, 0); pb(3, 8'h5C, 1, 0);
        pb(3, 8'h2E, 0, 0); pb(3, 8'h17, 0, 0); pb(3, 8'hB3, 1, 0);
        do_start(3, 3);
        pat[3] = 2'd0;
        repeat (2) @(negedge clk);
        st[3] = 1'b1;
        @(negedge clk);
        st[3] = 1'b0;
        repeat (3) @(negedge clk);
        chk("lfsr frame_done", int'(fd[3]), 1);
        st[3] = 1'b1;
        @(negedge clk);
        st[3] = 1'b0;
        chk("start in DONE ignored", int'(busy[3]), 0);
        repeat (3) @(negedge clk);
        chk("no queued start", int'(busy[3]), 0);
        pb(3, 8'h01, 0, 1); pb(3, 8'hB8, 0, 0); pb(3, 8'h5C, 1, 0);
        pb(3, 8'h2E, 0, 0); pb(3, 8'h17, 0, 0); pb(3, 8'hB3, 1, 0);
        do_start(3, 3);
        wait_idle(3);

        // start held high for 12 edges: exactly two frames (second from the IDLE cycle).
        f0 = fd_cnt[0];
        for (int n = 0; n < 2; n++)
            for (int l = 0; l < 2; l++)
                for (int xx = 0; xx < 4; xx++)
                    pb(0, l, xx == 3, (l == 0) && (xx == 0));
        @(negedge clk);
        st[0]  = 1'b1;
        pat[0] = 2'd1;
        repeat (12) @(negedge clk);
        st[0]  = 1'b0;
        wait_idle(0);
        repeat (3) @(negedge clk);
        chk("held start frame count", fd_cnt[0] - f0, 2);
        chk("held start no third frame", int'(busy[0]), 0);

        // Reset on the 3rd beat of the second line aborts the frame.
        pb(0, 0, 0, 1); pb(0, 1, 0, 0); pb(0, 2, 0, 0); pb(0, 3, 1, 0);
        pb(0, 0, 0, 0); pb(0, 1, 0, 0); pb(0, 2, 0, 0);
        f0 = fd_cnt[0];
        do_start(0, 0);
        repeat (6) @(negedge clk);
        chk("abort beat present", int'(tv[0]), 1);
        rstn[0] = 1'b0;
        @(negedge clk);
        chk("abort tvalid", int'(tv[0]), 0);
        chk("abort tlast", int'(tl[0]), 0);
        chk("abort busy", int'(busy[0]), 0);
        rstn[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort no frame_done", fd_cnt[0] - f0, 0);
        chk("abort queue drained", exp_q[0].size(), 0);
        push_frame(0, 4, 2, 0);
        do_start(0, 0);
        chk("restart tuser", int'(tu[0]), 1);
        chk("restart tdata", int'(td[0]), 0);
        wait_idle(0);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk($sformatf("dut%0d scoreboard empty", i), exp_q[i].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
